serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1 bit: mode, 0 = ip1+ip2+c_in, 1 = ip1-ip2; sampled with start.
REQ-006 The block SHALL have port ip1, input, WIDTH bits: first operand, sampled with start.
REQ-007 The block SHALL have port ip2, input, WIDTH bits: second operand, sampled with start.
REQ-008 The block SHALL have port c_in, input, 1 bit: carry-in, sampled with start, ignored when sub=1.
REQ-009 The block SHALL have port sum, output, WIDTH bits: registered result of the last completed operation.
REQ-010 The block SHALL have port c_out, output, 1 bit: carry out of the MSB (for sub: 1 = no borrow).
REQ-011 The block SHALL have port overflow, output, 1 bit: two's-complement overflow of the last result.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The block SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after WIDTH bit cycles, DONE->IDLE unconditionally after one cycle.
REQ-015 On the accept edge (IDLE, start=1) the block SHALL load ip1, ip2 (inverted when sub=1) into internal shift registers, set the carry flop to c_in (to 1 when sub=1), and clear the bit counter.
REQ-016 In RUN the block SHALL process one bit per cycle, LSB first, using the full-adder equations s = a^b^c, c' = ab|ac|bc, shifting s into an internal result register.
REQ-017 On the WIDTH-th RUN edge the block SHALL update sum, c_out (final carry) and overflow (carry into MSB XOR carry out of MSB) and enter DONE.
REQ-018 done SHALL be high exactly in the DONE cycle, i.e. first seen high WIDTH+1 rising edges after the accept edge's preceding cycle (WIDTH cycles after accept), and SHALL be low otherwise.
REQ-019 sum, c_out and overflow SHALL hold their values from completion until the next completion or reset; partial results SHALL never be visible on sum.
REQ-020 start SHALL be ignored in RUN and DONE; operands changing during RUN SHALL not affect the result.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; WIDTH=1 SHALL behave as a registered single full adder.
REQ-022 busy SHALL be high from the cycle after the accept edge until and including the last RUN cycle.

Reset
REQ-023 When rst=1 at a rising edge the block SHALL enter IDLE and clear sum, c_out, overflow, busy, done and all internal registers to 0.
REQ-024 rst SHALL take priority over start and over an operation in progress; an aborted operation SHALL produce no done pulse and SHALL not update sum.

Verification (WIDTH=8 unless stated)
REQ-025 Reset: rst high 2 cycles -> sum=8'h00, c_out=0, overflow=0, busy=0, done=0.
REQ-026 Add wrap: ip1=8'hFF, ip2=8'h01, c_in=0, sub=0, start -> busy 8 cycles, done pulse one cycle, sum=8'h00, c_out=1, overflow=0.
REQ-027 Signed overflow: ip1=8'h7F, ip2=8'h01, c_in=0 -> sum=8'h80, c_out=0, overflow=1; sub 8'h80-8'h01 -> sum=8'h7F, c_out=1, overflow=1.
REQ-028 Subtract with borrow: sub=1, ip1=8'h05, ip2=8'h07 -> sum=8'hFE, c_out=0, overflow=0.
REQ-029 Ignored start: second start with ip1=8'h10, ip2=8'h10 at RUN cycle 3 of 8'h01+8'h02 -> sum=8'h03, single done pulse.
REQ-030 Reset mid-run: rst at RUN cycle 4 after a prior result 8'h03 -> busy=0 next cycle, no done, sum=8'h00; WIDTH=1 bench sweeps all 8 (ip1,ip2,c_in) rows -> sum/c_out match full-adder truth table.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: operands are captured on start and processed one bit per clock, LSB first.
// Results (sum, carry, signed overflow) are published only when the final bit completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             bit_sum;
    logic             carry_next;
    logic             last_bit;

    // Full-adder slice on the current LSBs; new bit enters the result from the top.
    always_comb begin
        bit_sum    = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        last_bit   = (cnt == CW'(WIDTH - 1));
        res_next   = (res_sr >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered outputs; subtraction is ip1 + ~ip2 + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= ip1;
                        b_sr  <= sub ? ~ip2 : ip2;
                        carry <= sub ? 1'b1 : c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_next;
                    res_sr <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum      <= res_next;
                        c_out    <= carry_next;
                        overflow <= carry ^ carry_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 instance (table, corner sequences, random vs model)
// and a WIDTH=1 instance swept over the full-adder truth table.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, sub8, cin8;
    logic [7:0] ip1_8, ip2_8, sum8;
    logic       cout8, ovf8, busy8, done8;
    logic       start1, sub1, cin1;
    logic [0:0] ip1_1, ip2_1, sum1;
    logic       cout1, ovf1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .ip1(ip1_8), .ip2(ip2_8),
        .c_in(cin8), .sum(sum8), .c_out(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .ip1(ip1_1), .ip2(ip2_1),
        .c_in(cin1), .sum(sum1), .c_out(cout1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] r;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model8(input logic s, input logic [7:0] a, input logic [7:0] b,
                                   input logic c, output logic [7:0] r, output logic co,
                                   output logic ov);
        int ua, ub, sa, sb, full, sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            full = ua - ub;
            co   = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + int'(c);
            co   = (full > 255);
            sres = sa + sb + int'(c);
        end
        r  = full[7:0];
        ov = (sres > 127) || (sres < -128);
    endfunction

    task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] er, input logic eco, input logic eov, input string tag);
        int         busy_n  = 0;
        int         done_n  = 0;
        int         done_at = -1;
        int         partial = 0;
        logic [7:0] prev;
        prev  = sum8;
        sub8  = s; ip1_8 = a; ip2_8 = b; cin8 = c; start8 = 1'b1;
        step();
        start8 = 1'b0;
        ip1_8  = ~a;
        ip2_8  = ~b;
        for (int i = 0; i < 12; i++) begin
            if (busy8) busy_n++;
            if (busy8 && sum8 !== prev) partial++;
            if (done8) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            step();
        end
        chk({tag, " busy_cycles"}, busy_n, 8);
        chk({tag, " done_pulses"}, done_n, 1);
        chk({tag, " done_latency"}, done_at, 8);
        chk({tag, " partial_sum"}, partial, 0);
        chk({tag, " sum"}, sum8, er);
        chk({tag, " c_out"}, cout8, eco);
        chk({tag, " overflow"}, ovf8, eov);
    endtask

    task automatic run1(input logic a, input logic b, input logic c, input string tag);
        int   busy_n  = 0;
        int   done_n  = 0;
        int   done_at = -1;
        int   total, sres;
        total = int'(a) + int'(b) + int'(c);
        sres  = -int'(a) - int'(b) + int'(c);
        sub1 = 1'b0; ip1_1 = a; ip2_1 = b; cin1 = c; start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (busy1) busy_n++;
            if (done1) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            step();
        end
        chk({tag, " busy_cycles"}, busy_n, 1);
        chk({tag, " done_pulses"}, done_n, 1);
        chk({tag, " done_latency"}, done_at, 1);
        chk({tag, " sum"}, sum1, total % 2);
        chk({tag, " c_out"}, cout1, (total > 1) ? 1 : 0);
        chk({tag, " overflow"}, ovf1, ((sres > 0) || (sres < -1)) ? 1 : 0);
    endtask

    initial begin
        logic [7:0] rr;
        logic       rco, rov;
        logic       rs, rc;
        logic [7:0] ra, rb;
        int         done_n;
        int         busy_n;
        int         done_at;

        tbl[0] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; ip1_8 = 8'h00; ip2_8 = 8'h00;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; ip1_1 = 1'b0; ip2_1 = 1'b0;
        step();
        step();
        chk("reset sum", sum8, 8'h00);
        chk("reset c_out", cout8, 1'b0);
        chk("reset overflow", ovf8, 1'b0);
        chk("reset busy", busy8, 1'b0);
        chk("reset done", done8, 1'b0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run8(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].r, tbl[i].co, tbl[i].ov,
                 $sformatf("vec%0d", i));
        end

        // Second start during RUN cycle 3 must be ignored.
        sub8 = 1'b0; ip1_8 = 8'h01; ip2_8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8  = 1'b0;
        done_n  = 0;
        done_at = -1;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                start8 = 1'b1; ip1_8 = 8'h10; ip2_8 = 8'h10; sub8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (done8) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            step();
        end
        chk("ignored_start done_pulses", done_n, 1);
        chk("ignored_start done_latency", done_at, 8);
        chk("ignored_start sum", sum8, 8'h03);
        chk("ignored_start idle", busy8, 1'b0);

        // Reset during RUN cycle 4 aborts with no done and clears the prior result.
        sub8 = 1'b0; ip1_8 = 8'h20; ip2_8 = 8'h30; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        chk("abort busy_before", busy8, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", busy8, 1'b0);
        chk("abort done", done8, 1'b0);
        chk("abort sum", sum8, 8'h00);
        done_n = 0;
        busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) done_n++;
            if (busy8) busy_n++;
            step();
        end
        chk("abort no_done", done_n, 0);
        chk("abort no_busy", busy_n, 0);
        chk("abort sum_held", sum8, 8'h00);

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            model8(rs, ra, rb, rc, rr, rco, rov);
            run8(rs, ra, rb, rc, rr, rco, rov, $sformatf("rand%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            run1(1'(i >> 2), 1'(i >> 1), 1'(i), $sformatf("w1_row%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
